qam_demodulation: RTL
=====================

# qam_demodulation

Avalon-ST hard-decision QAM demapper: the receive-side counterpart of `QAM_Modulation`. It accepts I/Q symbol beats, slices each symbol to log2(QAM_STAGE) bits with the inverse Gray mapping, and emits packed bit beats. The block sits between the channel or equalizer output and the bit sink. It runs a 2-stage valid/ready pipeline with packet framing checks.

## Interface
- `MAX_PACKET_BEATS`, 1024, forwarded beats per packet before EOP is forced.
- `QAM_STAGE`, 4, constellation size; legal values are 4 (QPSK) and 16.
- `MOD_IN_WIDTH`, 4, signed two's-complement width of each I and Q sample.
- `PIPELINE_DEEPTH`, 1, symbols per beat.
- Derived: B = $clog2(QAM_STAGE), W = MOD_IN_WIDTH, T = 2**(W-2) (16-QAM threshold).
- `clock_clk` in 1: single clock, rising edge.
- `reset_reset` in 1: synchronous, active-high reset.
- `asi_in0_data` in PIPELINE_DEEPTH*W*2: symbol k occupies [k*2W +: 2W]; I is the low W bits, Q is the high W bits.
- `asi_in0_ready` out 1: sink ready.
- `asi_in0_valid` in 1: beat valid.
- `asi_in0_empty` in 1: passed through with the beat.
- `asi_in0_startofpacket` in 1: first beat of a packet.
- `asi_in0_endofpacket` in 1: last beat of a packet.
- `aso_out0_data` out PIPELINE_DEEPTH*B: symbol k bits at [k*B +: B]; Q bits are the upper half, I bits the lower half.
- `aso_out0_ready` in 1: downstream ready.
- `aso_out0_valid` out 1: output beat valid.
- `aso_out0_endofpacket` out 1: last beat of the output packet.
- `aso_out0_startofpacket` out 1: first beat of the output packet.
- `aso_out0_empty` out 1: forwarded empty flag.

## Operation
- Slicing, per axis value x (signed):
  - QPSK: the axis bit is 1 when x >= 0, else 0.
  - 16-QAM: x < -T gives 2'b00; -T <= x < 0 gives 2'b01; 0 <= x < T gives 2'b11; x >= T gives 2'b10.
  - Out-of-range and most-negative values slice by these same compares; there is no saturation.
- Symbol output is {Q bits, I bits}.
- Framing FSM, states IDLE and PACKET. The beat counter `cnt` has width $clog2(MAX_PACKET_BEATS+1).
- IDLE:
  - A valid beat without SOP is accepted and dropped (not forwarded).
  - A beat with SOP is forwarded and sets cnt=1. The FSM goes to PACKET, unless EOP is also set on that beat.
- PACKET:
  - Each forwarded beat increments cnt.
  - EOP returns the FSM to IDLE.
  - SOP in PACKET restarts the packet: the beat is forwarded with SOP, cnt=1, and the state stays PACKET.
  - When the forwarded beat makes cnt == MAX_PACKET_BEATS without EOP, `aso_out0_endofpacket` is forced high on that beat and the FSM returns to IDLE.
- SOP, EOP and empty travel in the same pipeline slot as their data.

## Timing
- Pipeline:
  - Stage 1 registers the input beat and framing decision.
  - Stage 2 registers the sliced bits onto the aso outputs.
- Latency: a beat accepted at edge N is presented with `aso_out0_valid`=1 after edge N+1, provided stage 2 was free.
- Throughput: 1 beat per cycle when `aso_out0_ready`=1.
- `asi_in0_ready` = !reset_reset && (!s1_valid || !s2_valid || aso_out0_ready). This is combinational; there are no bubbles and no data loss under backpressure.
- A beat transfers when valid && ready on a rising edge. While `aso_out0_ready`=0, all aso outputs hold stable.
- Reset: while reset_reset=1 at an edge, both stages are invalidated and the FSM goes to IDLE with cnt=0. After that edge:
  - `aso_out0_valid`, `aso_out0_data`, `aso_out0_startofpacket`, `aso_out0_endofpacket` and `aso_out0_empty` are all 0.
  - `asi_in0_ready` is 0 while reset is asserted and 1 on the first cycle after.
- Reset mid-packet discards in-flight beats. No EOP is generated for the truncated packet.

## Configuration
- `QAM_DEMOD_DROP_CNT_EN` defined:
  - Adds the output port `drop_cnt` (16 bits). It counts beats dropped in IDLE, saturates at 16'hFFFF, and resets to 0.
- `QAM_DEMOD_DROP_CNT_EN` not defined:
  - The port and counter are absent; drops still occur silently.

## Test plan
- QPSK, W=4, depth 1: SOP+EOP beat with I=4'h3, Q=4'hD -> one output beat after 2 edges, data 2'b01, SOP=1, EOP=1.
- 16-QAM, W=4, T=4: I=4'h6, Q=4'hE -> data 4'b0110. I=4'hA, Q=4'h4 -> 4'b1000. I=4'h8, Q=4'h0 -> 4'b1100.
- Backpressure: 100 random beats while `aso_out0_ready` toggles with a 1-cycle-on, 2-cycle-off pattern -> all 100 beats are delivered in order, identical to the reference slicer model, with output stable while stalled.
- Framing: 3 beats without SOP, then a 4-beat packet -> only the 4 beats are output. With `QAM_DEMOD_DROP_CNT_EN`, drop_cnt=3.
- MAX_PACKET_BEATS=8: SOP then 10 beats without EOP -> beat 8 carries the forced EOP; beats 9-10 are dropped; the next SOP beat is forwarded.
- Reset asserted for 1 cycle with 2 beats in flight -> aso_out0_valid=0 after that edge, the beats are lost, and a new SOP packet passes normally.

Source files
------------

// File: rtl/qam_demodulation.sv
// qam_demodulation: Avalon-ST hard-decision QPSK/16-QAM demapper with packet framing.
// Two-stage valid/ready pipeline: stage 1 holds the raw I/Q beat and the framing
// decision, stage 2 holds the sliced bits that drive the aso outputs.
// Optional feature macro: QAM_DEMOD_DROP_CNT_EN adds a saturating drop_cnt output.
//
// Framing FSM
//   state     | meaning
//   ST_IDLE   | outside a packet; beats without SOP are accepted and dropped
//   ST_PACKET | inside a packet; every beat is forwarded and counted in cnt
module qam_demodulation #(
  parameter int MAX_PACKET_BEATS = 1024,
  parameter int QAM_STAGE        = 4,
  parameter int MOD_IN_WIDTH     = 4,
  parameter int PIPELINE_DEEPTH  = 1
) (
  input  logic                                        clock_clk,
  input  logic                                        reset_reset,
  input  logic [PIPELINE_DEEPTH*MOD_IN_WIDTH*2-1:0]   asi_in0_data,
  output logic                                        asi_in0_ready,
  input  logic                                        asi_in0_valid,
  input  logic                                        asi_in0_empty,
  input  logic                                        asi_in0_startofpacket,
  input  logic                                        asi_in0_endofpacket,
  output logic [PIPELINE_DEEPTH*$clog2(QAM_STAGE)-1:0] aso_out0_data,
  input  logic                                        aso_out0_ready,
  output logic                                        aso_out0_valid,
  output logic                                        aso_out0_endofpacket,
  output logic                                        aso_out0_startofpacket,
  output logic                                        aso_out0_empty
`ifdef QAM_DEMOD_DROP_CNT_EN
  ,
  output logic [15:0]                                 drop_cnt
`endif
);

  localparam int B  = $clog2(QAM_STAGE);
  localparam int H  = B / 2;
  localparam int W  = MOD_IN_WIDTH;
  localparam int DW = PIPELINE_DEEPTH * W * 2;
  localparam int OW = PIPELINE_DEEPTH * B;
  localparam int CW = $clog2(MAX_PACKET_BEATS + 1);
  localparam logic signed [W-1:0] T_POS = W'(2 ** (W - 2));
  localparam logic signed [W-1:0] T_NEG = W'(-(2 ** (W - 2)));
  localparam logic signed [W-1:0] ZERO  = '0;

  typedef enum logic {ST_IDLE, ST_PACKET} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            fwd, fwd_eop;
  logic            accept, s1_load, s2_load;

  logic            s1_valid, s1_sop, s1_eop, s1_empty;
  logic [DW-1:0]   s1_data;
  logic [OW-1:0]   sliced;

  // Per-axis slicer; 16-QAM levels map to Gray codes 00,01,11,10 from most negative up.
  function automatic logic [H-1:0] slice_axis(input logic signed [W-1:0] x);
    logic [1:0] r;
    if (QAM_STAGE == 16) begin
      if (x < T_NEG)      r = 2'b00;
      else if (x < ZERO)  r = 2'b01;
      else if (x < T_POS) r = 2'b11;
      else                r = 2'b10;
    end else begin
      r = {1'b0, (x >= ZERO)};
    end
    return r[H-1:0];
  endfunction

  // A stage may load when it is empty or its contents move on this edge.
  assign s2_load       = !aso_out0_valid || aso_out0_ready;
  assign s1_load       = !s1_valid || s2_load;
  assign asi_in0_ready = !reset_reset && s1_load;
  assign accept        = asi_in0_valid && asi_in0_ready;

  // Framing state register.
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Framing decision for the beat being accepted; SOP always (re)starts a packet.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fwd       = 1'b0;
    fwd_eop   = 1'b0;
    if (accept && (asi_in0_startofpacket || state == ST_PACKET)) begin
      fwd       = 1'b1;
      cnt_nxt   = asi_in0_startofpacket ? CW'(1) : cnt + CW'(1);
      fwd_eop   = asi_in0_endofpacket || (cnt_nxt == CW'(MAX_PACKET_BEATS));
      state_nxt = fwd_eop ? ST_IDLE : ST_PACKET;
    end
  end

  // Stage 1: raw beat plus framing; dropped beats leave the slot invalid.
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_empty <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= fwd;
      s1_data  <= asi_in0_data;
      s1_sop   <= asi_in0_startofpacket;
      s1_eop   <= fwd_eop;
      s1_empty <= asi_in0_empty;
    end
  end

  // Slice every symbol of the stage-1 beat into {Q bits, I bits}.
  always_comb begin
    sliced = '0;
    for (int k = 0; k < PIPELINE_DEEPTH; k++) begin
      sliced[k*B +: H]     = slice_axis(s1_data[k*2*W +: W]);
      sliced[k*B + H +: H] = slice_axis(s1_data[k*2*W + W +: W]);
    end
  end

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      aso_out0_valid         <= 1'b0;
      aso_out0_data          <= '0;
      aso_out0_startofpacket <= 1'b0;
      aso_out0_endofpacket   <= 1'b0;
      aso_out0_empty         <= 1'b0;
    end else if (s2_load) begin
      aso_out0_valid         <= s1_valid;
      aso_out0_data          <= sliced;
      aso_out0_startofpacket <= s1_sop;
      aso_out0_endofpacket   <= s1_eop;
      aso_out0_empty         <= s1_empty;
    end
  end

`ifdef QAM_DEMOD_DROP_CNT_EN
  logic drop;
  assign drop = accept && !fwd;

  // Saturating count of beats discarded outside a packet.
  always_ff @(posedge clock_clk) begin
    if (reset_reset)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule
